// File: rtl/polar_sweep_controller.sv
// Polar sweep controller: steps a servo through a ping-pong angle sweep,
// waits for settle, runs one range measurement per angle, feeds {theta,r}
// to an external polar-to-cartesian converter and hands each registered
// (x,y) point downstream over a valid/ready handshake.
module polar_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES  = 2_700_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_350_000,
  parameter logic [3:0]  ANGLE_MIN      = 4'h1,
  parameter logic [3:0]  ANGLE_MAX      = 4'h6,
  parameter int          CNT_W          = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [3:0]         servo_angle,
  output logic               meas_start,
  input  logic               meas_done,
  input  logic [7:0]         meas_distance,
  output logic [11:0]        r_theta,
  input  logic signed [11:0] conv_x,
  input  logic signed [11:0] conv_y,
  output logic signed [11:0] point_x,
  output logic signed [11:0] point_y,
  output logic [3:0]         point_angle,
  output logic               point_no_echo,
  output logic               point_valid,
  input  logic               point_ready,
  output logic               sweep_done,
  output logic               busy
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    MEASURE = 3'd2,
    CONVERT = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             dir_down;
  logic             no_echo_p0;

  // FSM strobes consumed by the datapath register block
  logic load_settle;
  logic load_timeout;
  logic cnt_dec;
  logic capture_echo;
  logic capture_none;
  logic latch_point;
  logic accept;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and control strobes; meas_done is ignored on the meas_start cycle
  always_comb begin
    next_state   = state;
    load_settle  = 1'b0;
    load_timeout = 1'b0;
    cnt_dec      = 1'b0;
    capture_echo = 1'b0;
    capture_none = 1'b0;
    latch_point  = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          load_settle = 1'b1;
          next_state  = MOVE;
        end
      end
      MOVE: begin
        if (cnt == '0) begin
          load_timeout = 1'b1;
          next_state   = MEASURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MEASURE: begin
        if (!meas_start && meas_done) begin
          capture_echo = 1'b1;
          next_state   = CONVERT;
        end else if (cnt == '0) begin
          capture_none = 1'b1;
          next_state   = CONVERT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CONVERT: begin
        latch_point = 1'b1;
        next_state  = OUTPUT;
      end
      OUTPUT: begin
        if (point_ready) begin
          accept = 1'b1;
          if (enable) begin
            load_settle = 1'b1;
            next_state  = MOVE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counter, {theta,r} stage, point stage and ping-pong angle stepping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      dir_down      <= 1'b0;
      servo_angle   <= ANGLE_MIN;
      meas_start    <= 1'b0;
      sweep_done    <= 1'b0;
      no_echo_p0    <= 1'b0;
      r_theta       <= '0;
      point_x       <= '0;
      point_y       <= '0;
      point_angle   <= '0;
      point_no_echo <= 1'b0;
      point_valid   <= 1'b0;
    end else begin
      meas_start <= load_timeout;
      sweep_done <= 1'b0;

      if (load_settle)       cnt <= SETTLE_LOAD;
      else if (load_timeout) cnt <= TIMEOUT_LOAD;
      else if (cnt_dec)      cnt <= cnt - 1'b1;

      if (capture_echo) begin
        r_theta    <= {servo_angle, meas_distance};
        no_echo_p0 <= 1'b0;
      end else if (capture_none) begin
        r_theta    <= {servo_angle, 8'h00};
        no_echo_p0 <= 1'b1;
      end

      if (latch_point) begin
        point_x       <= conv_x;
        point_y       <= conv_y;
        point_angle   <= servo_angle;
        point_no_echo <= no_echo_p0;
        point_valid   <= 1'b1;
      end

      if (accept) begin
        point_valid <= 1'b0;
        if (!dir_down) begin
          if (servo_angle < ANGLE_MAX) begin
            servo_angle <= servo_angle + 4'd1;
          end else begin
            dir_down    <= 1'b1;
            servo_angle <= ANGLE_MAX - 4'd1;
            sweep_done  <= 1'b1;
          end
        end else begin
          if (servo_angle > ANGLE_MIN) begin
            servo_angle <= servo_angle - 4'd1;
          end else begin
            dir_down    <= 1'b0;
            servo_angle <= ANGLE_MIN + 4'd1;
            sweep_done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_polar_sweep_controller.sv
// Bench for polar_sweep_controller with a behavioural polar-to-cartesian
// converter attached (theta = 30deg*index - 15deg, rounded to nearest).
module tb_polar_sweep_controller;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [3:0]         servo_angle;
  logic               meas_start;
  logic               meas_done = 1'b0;
  logic [7:0]         meas_distance = 8'd0;
  logic [11:0]        r_theta;
  logic signed [11:0] conv_x;
  logic signed [11:0] conv_y;
  logic signed [11:0] point_x;
  logic signed [11:0] point_y;
  logic [3:0]         point_angle;
  logic               point_no_echo;
  logic               point_valid;
  logic               point_ready = 1'b0;
  logic               sweep_done;
  logic               busy;

  typedef struct {
    int angle;
    int r;
    int no_echo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   exp_angle = 1;
  bit   exp_down  = 1'b0;

  always #5 clock = ~clock;

  polar_sweep_controller #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .ANGLE_MIN     (4'h1),
    .ANGLE_MAX     (4'h6),
    .CNT_W         (24)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .servo_angle  (servo_angle),
    .meas_start   (meas_start),
    .meas_done    (meas_done),
    .meas_distance(meas_distance),
    .r_theta      (r_theta),
    .conv_x       (conv_x),
    .conv_y       (conv_y),
    .point_x      (point_x),
    .point_y      (point_y),
    .point_angle  (point_angle),
    .point_no_echo(point_no_echo),
    .point_valid  (point_valid),
    .point_ready  (point_ready),
    .sweep_done   (sweep_done),
    .busy         (busy)
  );

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int conv(input int r, input int a, input bit want_y);
    real rad;
    rad = (30.0 * $itor(a) - 15.0) * 3.14159265358979 / 180.0;
    if (want_y) return rnd($itor(r) * $sin(rad));
    else        return rnd($itor(r) * $cos(rad));
  endfunction

  assign conv_x = 12'(conv(int'(r_theta[7:0]), int'(r_theta[11:8]), 1'b0));
  assign conv_y = 12'(conv(int'(r_theta[7:0]), int'(r_theta[11:8]), 1'b1));

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One full point: wait for meas_start, answer (or not), check latency,
  // compare against the scoreboard, optionally stall ready, then handshake.
  task automatic do_point(input int r, input bit echo, input int hold);
    exp_t e;
    bit   seen;
    int   hx, hy, ha, hr;
    int   exp_sweep;
    point_ready = (hold == 0);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clock);
      if (meas_start) seen = 1'b1;
    end
    check("meas_start_seen", int'(seen), 1);
    check("servo_angle_meas", int'(servo_angle), exp_angle);
    e.angle   = exp_angle;
    e.r       = echo ? r : 0;
    e.no_echo = echo ? 0 : 1;
    sb.push_back(e);
    if (echo) begin
      @(negedge clock);
      meas_distance = 8'(r);
      meas_done     = 1'b1;
      @(negedge clock);
      meas_done     = 1'b0;
      meas_distance = 8'd0;
      check("valid_after_1clk", int'(point_valid), 0);
    end else begin
      repeat (TIMEOUT) @(negedge clock);
      check("valid_before_timeout_pt", int'(point_valid), 0);
    end
    check("r_theta", int'(r_theta), (e.angle << 8) | e.r);
    @(negedge clock);
    check("valid_after_2clk", int'(point_valid), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("point_angle", int'(point_angle), e.angle);
      check("point_x", int'(point_x), conv(e.r, e.angle, 1'b0));
      check("point_y", int'(point_y), conv(e.r, e.angle, 1'b1));
      check("point_no_echo", int'(point_no_echo), e.no_echo);
    end
    if (hold > 0) begin
      hx = int'(point_x);
      hy = int'(point_y);
      ha = int'(point_angle);
      hr = int'(r_theta);
      repeat (hold) begin
        @(negedge clock);
        check("hold_valid", int'(point_valid), 1);
        check("hold_x", int'(point_x), hx);
        check("hold_y", int'(point_y), hy);
        check("hold_angle", int'(point_angle), ha);
        check("hold_r_theta", int'(r_theta), hr);
        check("hold_servo", int'(servo_angle), e.angle);
      end
      point_ready = 1'b1;
    end
    @(negedge clock);
    exp_sweep = 0;
    if (!exp_down) begin
      if (exp_angle < 6) exp_angle++;
      else begin exp_down = 1'b1; exp_angle = 5; exp_sweep = 1; end
    end else begin
      if (exp_angle > 1) exp_angle--;
      else begin exp_down = 1'b0; exp_angle = 2; exp_sweep = 1; end
    end
    check("valid_cleared", int'(point_valid), 0);
    check("servo_next", int'(servo_angle), exp_angle);
    check("sweep_done", int'(sweep_done), exp_sweep);
    check("busy_after_accept", int'(busy), int'(enable));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit any_valid;
    bit any_start;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_servo", int'(servo_angle), 1);
    check("rst_valid", int'(point_valid), 0);
    check("rst_meas_start", int'(meas_start), 0);
    check("rst_r_theta", int'(r_theta), 0);
    check("rst_point_x", int'(point_x), 0);
    check("rst_sweep_done", int'(sweep_done), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", int'(busy), 0);

    // First point at angle 1, r=100, with ready stalled for 10 clocks
    enable = 1'b1;
    do_point(100, 1'b1, 10);
    check("ref_point_x_const", conv(100, 1, 1'b0), 97);

    // Free-running ping-pong: angles 2,3,4,5,6,5,4,3,2,1,2
    for (int i = 0; i < 11; i++) do_point(20 + 21 * i, 1'b1, 0);

    // Timeout: no echo at angle 3
    do_point(0, 1'b0, 0);

    // enable dropped during MOVE: point completes, then idle with angle advanced
    enable = 1'b0;
    do_point(77, 1'b1, 0);
    any_start = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (meas_start || busy) any_start = 1'b1;
    end
    check("stopped_idle", int'(any_start), 0);
    check("angle_retained", int'(servo_angle), exp_angle);

    // Reset asserted during MEASURE
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clock);
      if (meas_start) seen = 1'b1;
    end
    check("meas_start_before_rst", int'(seen), 1);
    @(negedge clock);
    meas_distance = 8'd55;
    meas_done     = 1'b1;
    reset         = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_servo", int'(servo_angle), 1);
    check("midrst_r_theta", int'(r_theta), 0);
    meas_done     = 1'b0;
    meas_distance = 8'd0;
    enable        = 1'b0;
    any_valid     = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (point_valid) any_valid = 1'b1;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (point_valid) any_valid = 1'b1;
    end
    check("midrst_no_point", int'(any_valid), 0);
    exp_angle = 1;
    exp_down  = 1'b0;
    sb.delete();

    // Restart after reset begins again at angle 1 going up
    enable = 1'b1;
    do_point(150, 1'b1, 0);
    enable = 1'b0;
    repeat (4) @(negedge clock);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
